// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU: opcodes, flag bit
// positions and the control FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_MV    = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0001;
  localparam logic [3:0] OP_PASS2 = 4'b0010;
  localparam logic [3:0] OP_PASS3 = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHRL  = 4'b0101;
  localparam logic [3:0] OP_ROR   = 4'b0110;
  localparam logic [3:0] OP_SHRA  = 4'b0111;
  localparam logic [3:0] OP_ROL   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_OR    = 4'b1011;
  localparam logic [3:0] OP_AND   = 4'b1100;
  localparam logic [3:0] OP_SUB   = 4'b1101;
  localparam logic [3:0] OP_ADD   = 4'b1110;
  localparam logic [3:0] OP_PASS  = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done and product are presented combinationally on the final step.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_sum_s;
  logic             last_s;

  // Partial-product accumulation and next-state for the iteration registers
  always_comb begin
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    last_s    = busy_q && (cnt_q == SHW'(WIDTH - 1));
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start) begin
      acc_d    = {WIDTH{1'b0}};
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = {SHW{1'b0}};
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_sum_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
      busy_d   = !last_s;
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Iteration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = last_s;
  assign product = acc_sum_s;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with registered result/flags and an iterative
// multiplier. Shift/rotate amount comes from a; the shifted value from b.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  localparam int LANES = WIDTH / 8,
  localparam int SHW   = $clog2(WIDTH),
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [LW-1:0]    lane,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept_s;
  logic             mul_start_s, mul_busy_s, mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [SHW-1:0]   amt_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] mv_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s, alu_v_s;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign amt_s    = a[SHW-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Single-cycle operation mux with carry/overflow for ADD and SUB
  always_comb begin
    add_s     = {1'b0, a} + {1'b0, b};
    sub_s     = b - a;
    alu_res_s = b;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    // lane 0 addresses the most-significant byte
    for (int i = 0; i < LANES; i++) begin
      mv_s[i*8 +: 8] = (lane == LW'(LANES - 1 - i)) ? b[7:0] : a[i*8 +: 8];
    end
    case (op)
      OP_MV:   alu_res_s = mv_s;
      OP_SHL:  alu_res_s = b << amt_s;
      OP_SHRL: alu_res_s = b >> amt_s;
      OP_SHRA: alu_res_s = $signed(b) >>> amt_s;
      OP_ROR:  alu_res_s = WIDTH'({b, b} >> amt_s);
      OP_ROL:  alu_res_s = WIDTH'(({b, b} << amt_s) >> WIDTH);
      OP_NOT:  alu_res_s = ~b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_OR:   alu_res_s = a | b;
      OP_AND:  alu_res_s = a & b;
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_c_s   = (b < a);
        alu_v_s   = (b[WIDTH-1] != a[WIDTH-1]) && (sub_s[WIDTH-1] != b[WIDTH-1]);
      end
      OP_ADD: begin
        alu_res_s = add_s[WIDTH-1:0];
        alu_c_s   = add_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res_s = b;
    endcase
  end

  // Control FSM and output register next-state
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (op == OP_MUL)) begin
          state_d     = S_MUL;
          mul_start_s = 1'b1;
          out_valid_d = 1'b0;
        end else if (accept_s) begin
          out_valid_d      = 1'b1;
          result_d         = alu_res_s;
          flags_d[FLAG_N]  = alu_res_s[WIDTH-1];
          flags_d[FLAG_Z]  = (alu_res_s == {WIDTH{1'b0}});
          flags_d[FLAG_C]  = alu_c_s;
          flags_d[FLAG_V]  = alu_v_s;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_MUL: begin
        if (mul_done_s) begin
          state_d         = S_IDLE;
          out_valid_d     = 1'b1;
          result_d        = mul_prod_s;
          flags_d[FLAG_N] = mul_prod_s[WIDTH-1];
          flags_d[FLAG_Z] = (mul_prod_s == {WIDTH{1'b0}});
          flags_d[FLAG_C] = 1'b0;
          flags_d[FLAG_V] = 1'b0;
        end else if (!mul_busy_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized self-checking bench for alu_pipe (WIDTH=32) against a queue-based
// behavioural model that predicts result, flags and handshake timing.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [1:0]  lane = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          rdy;
  } exp_t;
  exp_t q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .lane      (lane),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference ALU from plain 64-bit arithmetic
  function automatic void ref_alu(input logic [3:0] o, input logic [1:0] l,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output logic [3:0] f);
    longint unsigned aa, bb, m, rr;
    longint sa, sb, sr;
    int s, sh;
    bit c, v;
    aa = av; bb = bv; m = 64'hFFFF_FFFF;
    s = int'(av[4:0]);
    c = 1'b0; v = 1'b0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      4'd0: begin
        sh = (3 - int'(l)) * 8;
        rr = (aa & ~(64'hFF << sh)) | ((bb & 64'hFF) << sh);
      end
      4'd1:  rr = aa * bb;
      4'd4:  rr = bb << s;
      4'd5:  rr = bb >> s;
      4'd7:  rr = bv[31] ? ((bb >> s) | (m & ~(m >> s))) : (bb >> s);
      4'd6:  rr = (bb >> s) | (bb << (32 - s));
      4'd8:  rr = (bb << s) | (bb >> (32 - s));
      4'd9:  rr = ~bb;
      4'd10: rr = aa ^ bb;
      4'd11: rr = aa | bb;
      4'd12: rr = aa & bb;
      4'd13: begin
        rr = bb - aa;
        c  = (bb < aa);
        sr = sb - sa;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd14: begin
        rr = aa + bb;
        c  = (rr > m);
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: rr = bb;
    endcase
    r = rr[31:0];
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Compare process: predicts handshake and checks outputs every cycle
  always @(negedge clk) begin
    logic [31:0] r;
    logic [3:0]  f;
    bit exp_ov, exp_ir;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].rdy);
      exp_ir = (q.size() == 0) || (exp_ov && out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_ov && out_valid) begin
        chk("result", 64'(result), 64'(q[0].res));
        chk("flags", 64'(flags), 64'(q[0].fl));
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        ref_alu(op, lane, a, b, r, f);
        e.res = r;
        e.fl  = f;
        e.rdy = cyc + ((op == OP_MUL) ? (W + 1) : 1);
        q.push_back(e);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [3:0] o, input logic [1:0] l,
                      input logic [31:0] av, input logic [31:0] bv);
    bit got;
    got = 1'b0;
    op = o; lane = l; a = av; b = bv; in_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int n;

    // Model pinned against hand-computed values
    ref_alu(OP_ADD, 2'd0, 32'h7FFF_FFFF, 32'd1, r, f);
    chk("model_add_res", 64'(r), 64'h8000_0000);
    chk("model_add_fl", 64'(f), 64'h9);
    ref_alu(OP_SUB, 2'd0, 32'd5, 32'd3, r, f);
    chk("model_sub_res", 64'(r), 64'hFFFF_FFFE);
    chk("model_sub_fl", 64'(f), 64'hA);
    ref_alu(OP_SUB, 2'd0, 32'd3, 32'd3, r, f);
    chk("model_subz_fl", 64'(f), 64'h4);
    ref_alu(OP_MV, 2'd1, 32'h1122_3344, 32'h0000_00AB, r, f);
    chk("model_mv", 64'(r), 64'h11AB_3344);
    ref_alu(OP_ROR, 2'd0, 32'd8, 32'h1234_5678, r, f);
    chk("model_ror", 64'(r), 64'h7812_3456);
    ref_alu(OP_SHRA, 2'd0, 32'd4, 32'h8000_0000, r, f);
    chk("model_shra", 64'(r), 64'hF800_0000);
    ref_alu(OP_ROL, 2'd0, 32'd4, 32'h8000_0001, r, f);
    chk("model_rol", 64'(r), 64'h0000_0018);
    ref_alu(OP_MUL, 2'd0, 32'h0001_0001, 32'h0001_0001, r, f);
    chk("model_mul", 64'(r), 64'h0002_0001);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    @(posedge clk);
    #1;

    // Directed test-plan operations
    send(OP_ADD, 2'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add_lit_res", 64'(result), 64'h8000_0000);
    chk("add_lit_fl", 64'(flags), 64'h9);
    send(OP_SUB, 2'd0, 32'd5, 32'd3);
    send(OP_SUB, 2'd0, 32'd3, 32'd3);
    send(OP_MV, 2'd1, 32'h1122_3344, 32'h0000_00AB);
    send(OP_ROR, 2'd0, 32'd8, 32'h1234_5678);
    send(OP_SHRA, 2'd0, 32'd4, 32'h8000_0000);
    send(OP_SHL, 2'd0, 32'd0, 32'hDEAD_BEEF);
    send(OP_MUL, 2'd0, 32'h0001_0001, 32'h0001_0001);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mul_latency", 64'(n), 64'd33);
    chk("mul_lit_res", 64'(result), 64'h0002_0001);
    @(posedge clk);
    #1;

    // Back-pressure: first ADD held, second stalls until the drain
    out_ready = 1'b0;
    send(OP_ADD, 2'd0, 32'd1, 32'd2);
    op = OP_ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(result), 64'd3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_ADD, 2'd0, 32'd10, 32'd20);
    send(OP_ADD, 2'd0, 32'd100, 32'd200);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    send(OP_MUL, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ro = 4'($urandom_range(0, 15));
      if (ro == OP_MUL && $urandom_range(0, 3) != 0) ro = OP_ADD;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = ra & 32'h0000_0007;
      send(ro, 2'($urandom_range(0, 3)), ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (40) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
